// File: rtl/lfsr_encrypt_engine.sv
// LFSR stream-cipher engine on the shared data-memory port: reads key/plaintext, writes 64 ciphertext bytes.
// Build option ENC_PARITY_EN: ciphertext msb carries even parity over the 7 cipher bits (else 0).
module lfsr_encrypt_engine (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  output logic       Ack,
  output logic [7:0] MemAddr,
  output logic       MemRdEn,
  input  logic [7:0] MemRdData,
  output logic       MemWrEn,
  output logic [7:0] MemWrData
);

  localparam int unsigned MSG_BASE = 0;
  localparam int unsigned MSG_MAX  = 61;
  localparam int unsigned CFG_BASE = 61;
  localparam int unsigned OUT_BASE = 64;
  localparam int unsigned OUT_LEN  = 64;
  localparam int unsigned PRE_MIN  = 10;
  localparam int unsigned PRE_MAX  = 15;
  localparam int unsigned AW       = 8;
  localparam int unsigned IW       = 7;

  typedef enum logic [3:0] {
    IDLE, LD_PRE, LD_PRE_CAP, LD_PTN, LD_PTN_CAP, LD_INIT, LD_INIT_CAP, RD, WR, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [IW-1:0]   pre_q, pre_d;
  logic [6:0]      lfsr_q, lfsr_d;
  logic [6:0]      taps_q, taps_d;
  logic            start_q;
  logic            ack_q, ack_d;
  logic            fin_q, fin_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            rd_en_q, rd_en_d;
  logic            wr_en_q, wr_en_d;
  logic            pad_q, pad_d;
  logic [7:0]      plain;
  logic [6:0]      cipher;
  logic            msb;

  function automatic logic is_msg(input logic [IW-1:0] idx, input logic [IW-1:0] pre);
    logic [IW-1:0] k;
    k = idx - pre;
    return (idx >= pre) && (k < IW'(MSG_MAX));
  endfunction

  function automatic logic [IW-1:0] clamp_pre(input logic [7:0] v);
    if (v < 8'(PRE_MIN))      return IW'(PRE_MIN);
    else if (v > 8'(PRE_MAX)) return IW'(PRE_MAX);
    else                      return v[IW-1:0];
  endfunction

  function automatic logic [6:0] tap_lookup(input logic [3:0] pt);
    case (pt)
      4'd1:    return 7'h48;
      4'd2:    return 7'h78;
      4'd3:    return 7'h72;
      4'd4:    return 7'h6A;
      4'd5:    return 7'h69;
      4'd6:    return 7'h5C;
      4'd7:    return 7'h7E;
      4'd8:    return 7'h7B;
      default: return 7'h60;
    endcase
  endfunction

  // State and datapath registers
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      pre_q   <= IW'(PRE_MIN);
      lfsr_q  <= 7'h01;
      taps_q  <= 7'h60;
      start_q <= 1'b0;
      ack_q   <= 1'b0;
      fin_q   <= 1'b0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      pad_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      pre_q   <= pre_d;
      lfsr_q  <= lfsr_d;
      taps_q  <= taps_d;
      start_q <= Start;
      ack_q   <= ack_d;
      fin_q   <= fin_d;
      addr_q  <= addr_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      pad_q   <= pad_d;
    end
  end

  // Next state, datapath updates, and memory-port outputs decoded from the next state
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    pre_d   = pre_q;
    lfsr_d  = lfsr_q;
    taps_d  = taps_q;
    ack_d   = ack_q;
    fin_d   = 1'b0;
    rd_en_d = 1'b0;
    wr_en_d = 1'b0;
    addr_d  = '0;

    case (state_q)
      IDLE, DONE: begin
        if (fin_q)                  ack_d = 1'b1;
        else if (Start && !start_q) ack_d = 1'b0;
        if (start_q && !Start) begin
          state_d = LD_PRE;
          i_d     = '0;
          ack_d   = 1'b0;
        end
      end
      LD_PRE:     state_d = LD_PRE_CAP;
      LD_PRE_CAP: begin
        pre_d   = clamp_pre(MemRdData);
        state_d = LD_PTN;
      end
      LD_PTN:     state_d = LD_PTN_CAP;
      LD_PTN_CAP: begin
        taps_d  = tap_lookup(MemRdData[3:0]);
        state_d = LD_INIT;
      end
      LD_INIT:    state_d = LD_INIT_CAP;
      LD_INIT_CAP: begin
        lfsr_d  = (MemRdData[6:0] == 7'h00) ? 7'h01 : MemRdData[6:0];
        state_d = is_msg(i_q, pre_q) ? RD : WR;
      end
      RD:         state_d = WR;
      WR: begin
        lfsr_d = {lfsr_q[5:0], ^(lfsr_q & taps_q)};
        if (i_q == IW'(OUT_LEN - 1)) begin
          state_d = DONE;
          fin_d   = 1'b1;
        end else begin
          i_d     = i_q + IW'(1);
          state_d = is_msg(i_d, pre_q) ? RD : WR;
        end
      end
      default:    state_d = IDLE;
    endcase

    case (state_d)
      LD_PRE:  begin rd_en_d = 1'b1; addr_d = AW'(CFG_BASE);     end
      LD_PTN:  begin rd_en_d = 1'b1; addr_d = AW'(CFG_BASE + 1); end
      LD_INIT: begin rd_en_d = 1'b1; addr_d = AW'(CFG_BASE + 2); end
      RD:      begin rd_en_d = 1'b1; addr_d = AW'(MSG_BASE) + AW'(i_d - pre_d); end
      WR:      begin wr_en_d = 1'b1; addr_d = AW'(OUT_BASE) + AW'(i_d); end
      default: ;
    endcase
    pad_d = !is_msg(i_d, pre_d);
  end

  // Write data depends on read data returned during WR, so it is formed combinationally
  always_comb begin
    plain  = pad_q ? 8'h20 : MemRdData;
    cipher = plain[6:0] ^ lfsr_q;
`ifdef ENC_PARITY_EN
    msb    = ^cipher;
`else
    msb    = 1'b0;
`endif
    MemWrData = wr_en_q ? {msb, cipher} : 8'h00;
  end

  assign Ack     = ack_q;
  assign MemAddr = addr_q;
  assign MemRdEn = rd_en_q;
  assign MemWrEn = wr_en_q;

endmodule

// File: tb/tb_lfsr_encrypt_engine.sv
// Directed bench for lfsr_encrypt_engine: memory model, write scoreboard, latency and reset checks.
module tb_lfsr_encrypt_engine;

  logic       Clk, Reset, Start, Ack, MemRdEn, MemWrEn;
  logic [7:0] MemAddr, MemRdData, MemWrData;

  logic [7:0]  mem [256];
  logic [7:0]  msg [61];
  logic [7:0]  exp_b [64];
  logic [7:0]  t1_ref [64];
  logic [6:0]  tap_tbl [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
  logic [15:0] sb_q [$];
  int          exp_lat;
  int          errors = 0;
  int          checks = 0;
  int          overlaps = 0;

  lfsr_encrypt_engine dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .MemAddr   (MemAddr),
    .MemRdEn   (MemRdEn),
    .MemRdData (MemRdData),
    .MemWrEn   (MemWrEn),
    .MemWrData (MemWrData)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous data memory: read data appears the cycle after the strobe
  always @(posedge Clk) begin
    if (MemWrEn) mem[MemAddr] = MemWrData;
    if (MemRdEn) MemRdData <= mem[MemAddr];
  end

  // Write monitor: every committed write is popped from the scoreboard and compared
  always @(negedge Clk) begin
    logic [15:0] exp_w;
    if (MemRdEn && MemWrEn) overlaps++;
    if (Reset && MemWrEn) begin
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected_write observed addr=%0h data=%0h expected no write", MemAddr, MemWrData);
      end
      if (sb_q.size() != 0) begin
        exp_w = sb_q.pop_front();
        checks++;
        assert ({MemAddr, MemWrData} === exp_w) else begin
          errors++;
          $error("FAIL sb_write observed=%04h expected=%04h", {MemAddr, MemWrData}, exp_w);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model of the cipher stream and run latency
  task automatic build_expected(input logic [7:0] pre_raw, input logic [7:0] pt_raw, input logic [7:0] seed_raw);
    int         pre, k;
    logic [3:0] ptn;
    logic [6:0] taps, lf, x;
    logic [7:0] p;
    pre  = (pre_raw < 8'd10) ? 10 : (pre_raw > 8'd15) ? 15 : int'(pre_raw);
    ptn  = pt_raw[3:0];
    if (ptn > 4'd8) ptn = 4'd0;
    taps = tap_tbl[ptn];
    lf   = (seed_raw[6:0] == 7'h00) ? 7'h01 : seed_raw[6:0];
    for (int i = 0; i < 64; i++) begin
      k = i - pre;
      p = (k >= 0 && k < 61) ? msg[k] : 8'h20;
      x = p[6:0] ^ lf;
`ifdef ENC_PARITY_EN
      exp_b[i] = {^x, x};
`else
      exp_b[i] = {1'b0, x};
`endif
      lf = {lf[5:0], ^(lf & taps)};
    end
    exp_lat = 6 + 64 + (((64 - pre) < 61) ? (64 - pre) : 61) + 1;
  endtask

  task automatic setup(input logic [7:0] pre_raw, input logic [7:0] pt_raw, input logic [7:0] seed_raw);
    for (int j = 0; j < 61; j++) mem[j] = msg[j];
    mem[61] = pre_raw;
    mem[62] = pt_raw;
    mem[63] = seed_raw;
    build_expected(pre_raw, pt_raw, seed_raw);
    for (int i = 0; i < 64; i++) sb_q.push_back({8'(64 + i), exp_b[i]});
  endtask

  // Start high then low; returns just after the launch edge
  task automatic launch();
    @(negedge Clk) Start = 1'b1;
    @(negedge Clk) Start = 1'b0;
    @(posedge Clk);
  endtask

  task automatic wait_ack(input string tag);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    while (!got && n < 400) begin
      @(posedge Clk);
      n++;
      @(negedge Clk);
      if (Ack) got = 1'b1;
    end
    chk(tag, 16'(n), 16'(exp_lat));
  endtask

  task automatic chk_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[64 + i] !== exp_b[i]) bad++;
    chk(tag, 16'(bad), 16'd0);
    chk({tag, "_sb_drain"}, 16'(sb_q.size()), 16'd0);
  endtask

  initial begin
    string s;
    int    bad;
    s = "Mr. Watson, come here. I want to see you.";
    for (int j = 0; j < 61; j++) msg[j] = (j < s.len()) ? s[j] : 8'h20;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    Reset = 1'b0;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ack", 16'(Ack), 16'd0);
    chk("rst_rden", 16'(MemRdEn), 16'd0);
    chk("rst_wren", 16'(MemWrEn), 16'd0);
    chk("rst_addr", 16'(MemAddr), 16'd0);
    chk("rst_wdata", 16'(MemWrData), 16'd0);
    Reset = 1'b1;

    // T1: pre=10, pattern 0, seed 01
    setup(8'd10, 8'd0, 8'h01);
    launch();
    wait_ack("t1_latency");
    chk_mem("t1_mem");
    for (int i = 0; i < 64; i++) t1_ref[i] = mem[64 + i];

    // T6: relaunch from DONE with seed 7F; Ack must drop on the Start rise
    chk("t6_ack_before", 16'(Ack), 16'd1);
    setup(8'd10, 8'd0, 8'h7F);
    Start = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    chk("t6_ack_drop", 16'(Ack), 16'd0);
    Start = 1'b0;
    @(posedge Clk);
    wait_ack("t6_latency");
    chk_mem("t6_mem");

    // T2: pre below minimum clamps to 10, output identical to T1
    setup(8'd3, 8'd0, 8'h01);
    launch();
    wait_ack("t2_latency");
    chk_mem("t2_mem");
    bad = 0;
    for (int i = 0; i < 64; i++) if (mem[64 + i] !== t1_ref[i]) bad++;
    chk("t2_same_as_t1", 16'(bad), 16'd0);

    // T3: out-of-range pattern and zero seed fall back to 60 / 01
    setup(8'd10, 8'd9, 8'h00);
    launch();
    wait_ack("t3_latency");
    chk_mem("t3_mem");

    // T4: pattern 8, pre=15, all-space message
    for (int j = 0; j < 61; j++) msg[j] = 8'h20;
    setup(8'd15, 8'd8, 8'h35);
    launch();
    wait_ack("t4_latency");
    chk_mem("t4_mem");
    chk("t4_latency_120", 16'(exp_lat), 16'd120);

    // T5: reset 40 cycles into a T1 run; bytes 0..21 are written, the rest untouched
    for (int j = 0; j < 61; j++) msg[j] = (j < s.len()) ? s[j] : 8'h20;
    for (int i = 64; i < 128; i++) mem[i] = 8'hA5;
    setup(8'd10, 8'd0, 8'h01);
    launch();
    repeat (40) @(posedge Clk);
    @(negedge Clk);
    #1 Reset = 1'b0;
    #1;
    chk("t5_ack", 16'(Ack), 16'd0);
    chk("t5_rden", 16'(MemRdEn), 16'd0);
    chk("t5_wren", 16'(MemWrEn), 16'd0);
    chk("t5_sb_left", 16'(sb_q.size()), 16'd42);
    sb_q.delete();
    repeat (5) @(posedge Clk);
    @(negedge Clk);
    bad = 0;
    for (int i = 0; i < 22; i++) if (mem[64 + i] !== exp_b[i]) bad++;
    chk("t5_written", 16'(bad), 16'd0);
    bad = 0;
    for (int i = 22; i < 64; i++) if (mem[64 + i] !== 8'hA5) bad++;
    chk("t5_untouched", 16'(bad), 16'd0);
    Reset = 1'b1;
    repeat (2) @(posedge Clk);
    @(negedge Clk);

    chk("no_strobe_overlap", 16'(overlaps), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
